// File: rtl/emux_rx_pktbuf.sv
// emux_rx_pktbuf: receive packet buffer behind one emux_rx tap.
// Payload bytes go into a circular byte RAM. A packet becomes visible only
// after its CRC-good pulse. A small length FIFO hands committed packets to
// the client, which pops them one byte at a time.
// Optional build macro EMUX_RX_PKTBUF_STATS_EN adds the good_cnt/drop_cnt outputs.
module emux_rx_pktbuf #(
    parameter int aw       = 11,
    parameter int lw       = 3,
    parameter int crc_wait = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ready,
    input  logic          strobe,
    input  logic          crc,
    input  logic [7:0]    data,
    output logic          pkt_avail,
    output logic [aw:0]   pkt_len,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          rd_last,
    output logic          overflow
`ifdef EMUX_RX_PKTBUF_STATS_EN
    ,
    output logic [15:0]   good_cnt,
    output logic [15:0]   drop_cnt
`endif
);

    localparam int DEPTH  = 1 << aw;
    localparam int LDEPTH = 1 << lw;

    typedef enum logic [1:0] {IDLE, RECV, WAITC, DROP} state_t;

    state_t      state_q;
    logic [aw:0] wr_ptr_q, commit_ptr_q, rd_ptr_q, cnt_q, rd_cnt_q;
    logic [7:0]  timer_q;
    logic        strobe_prev_q, overflow_q;
    logic [7:0]  rd_data_q;
    logic        rd_valid_q, rd_last_q;
    logic [7:0]  ram [DEPTH];
    logic [aw:0] len_mem [LDEPTH];
    logic [lw-1:0] lhead_q, ltail_q;
    logic [lw:0]   lcnt_q;

    logic [aw:0] used, commit_len, commit_wp;
    logic        ram_full, active, wr_byte, ovf_byte, commit_try;
    logic        rd_acc, pop, len_full, push, commit_ovf, drop_evt;

    // Write-side decode: byte store, space check and commit outcome.
    // A byte arriving together with crc is stored and counted before the commit.
    always_comb begin
        used       = wr_ptr_q - rd_ptr_q;
        ram_full   = used[aw];
        active     = (state_q == RECV) && !ready;
        wr_byte    = active && strobe && !ram_full;
        ovf_byte   = active && strobe && ram_full;
        commit_try = !ready && crc &&
                     ((state_q == RECV && !ovf_byte) || state_q == WAITC);
        commit_len = cnt_q + (aw+1)'(wr_byte);
        commit_wp  = wr_ptr_q + (aw+1)'(wr_byte);
        pkt_avail  = (lcnt_q != '0);
        pkt_len    = pkt_avail ? len_mem[lhead_q] : '0;
        rd_acc     = rd_en && pkt_avail;
        pop        = rd_acc && ((rd_cnt_q + (aw+1)'(1)) == pkt_len);
        len_full   = lcnt_q[lw] && !pop;
        push       = commit_try && (commit_len != '0) && !len_full;
        commit_ovf = commit_try && (commit_len != '0) && len_full;
        drop_evt   = (ready && state_q != IDLE) || (commit_try && !push) || ovf_byte ||
                     (!ready && !crc && state_q == WAITC && timer_q == '0);
    end

    // Packet capture FSM: tracks the in-flight packet and rewinds on discard.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            cnt_q         <= '0;
            timer_q       <= '0;
            strobe_prev_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            overflow_q    <= ovf_byte || commit_ovf;
            strobe_prev_q <= strobe;
            if (ready) begin
                state_q  <= RECV;
                wr_ptr_q <= commit_ptr_q;
                cnt_q    <= '0;
            end else if (commit_try) begin
                state_q <= IDLE;
                if (push) begin
                    commit_ptr_q <= commit_wp;
                    wr_ptr_q     <= commit_wp;
                end else begin
                    wr_ptr_q <= commit_ptr_q;
                end
            end else begin
                case (state_q)
                    RECV: begin
                        if (ovf_byte) begin
                            wr_ptr_q <= commit_ptr_q;
                            state_q  <= DROP;
                            timer_q  <= 8'(crc_wait);
                        end else if (wr_byte) begin
                            wr_ptr_q <= wr_ptr_q + (aw+1)'(1);
                            cnt_q    <= cnt_q + (aw+1)'(1);
                        end else if (!strobe && strobe_prev_q) begin
                            state_q <= WAITC;
                            timer_q <= 8'(crc_wait);
                        end
                    end
                    WAITC: begin
                        if (timer_q == '0) begin
                            wr_ptr_q <= commit_ptr_q;
                            state_q  <= IDLE;
                        end else begin
                            timer_q <= timer_q - 8'd1;
                        end
                    end
                    DROP: begin
                        if (crc) begin
                            state_q <= IDLE;
                        end else if (strobe) begin
                            timer_q <= 8'(crc_wait);
                        end else if (timer_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            timer_q <= timer_q - 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Byte RAM write port.
    always_ff @(posedge clk) begin
        if (wr_byte) ram[wr_ptr_q[aw-1:0]] <= data;
    end

    // Length FIFO storage.
    always_ff @(posedge clk) begin
        if (push) len_mem[ltail_q] <= commit_len;
    end

    // Length FIFO pointers; a push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lhead_q <= '0;
            ltail_q <= '0;
            lcnt_q  <= '0;
        end else begin
            if (push) ltail_q <= ltail_q + 1'b1;
            if (pop)  lhead_q <= lhead_q + 1'b1;
            case ({push, pop})
                2'b10:   lcnt_q <= lcnt_q + 1'b1;
                2'b01:   lcnt_q <= lcnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Client read port: registered RAM read, head entry popped on its last byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            rd_last_q  <= pop;
            if (rd_acc) begin
                rd_data_q <= ram[rd_ptr_q[aw-1:0]];
                rd_ptr_q  <= rd_ptr_q + (aw+1)'(1);
                rd_cnt_q  <= pop ? '0 : rd_cnt_q + (aw+1)'(1);
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign overflow = overflow_q;

`ifdef EMUX_RX_PKTBUF_STATS_EN
    logic [15:0] good_cnt_q, drop_cnt_q;

    // Saturating good/drop packet counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            good_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push && good_cnt_q != '1)     good_cnt_q <= good_cnt_q + 16'd1;
            if (drop_evt && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign good_cnt = good_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop_evt;
`endif

endmodule
